// File: rtl/smg_scan_immdmod_pkg.sv
// smg_scan_immdmod_pkg: shared state encodings, digit count and default timing for the scanner
package smg_scan_immdmod_pkg;

    localparam int NUM_DIGITS       = 6;
    localparam int IDX_W            = $clog2(NUM_DIGITS);
    localparam int DEF_BLANK_T      = 500;
    localparam int DEF_SHOW_T       = 49500;
    localparam int DEF_BLINK_FRAMES = 250;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // active-low select pattern with only position i driven low
    function automatic logic [NUM_DIGITS-1:0] sel_mask(input logic [IDX_W-1:0] i);
        return ~(NUM_DIGITS'(1) << i);
    endfunction

endpackage

// File: rtl/smg_tick_cnt.sv
// smg_tick_cnt: enabled wrapping counter that flags its terminal count N-1
module smg_tick_cnt #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic done
);

    localparam int W = N > 1 ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign done = cnt == W'(N - 1);

    // advance while enabled, wrapping to zero on the terminal count so it never overflows
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (en) cnt <= done ? '0 : cnt + W'(1);

endmodule

// File: rtl/smg_scan_immdmod.sv
// smg_scan_immdmod: six-digit multiplexed display scanner with blanking, blink and decimal points
module smg_scan_immdmod
    import smg_scan_immdmod_pkg::*;
#(
    parameter int BLANK_T      = DEF_BLANK_T,
    parameter int SHOW_T       = DEF_SHOW_T,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic [4*NUM_DIGITS-1:0] iData,
    input  logic [NUM_DIGITS-1:0]   iBlink,
    input  logic [NUM_DIGITS-1:0]   iDp,
    output logic [3:0]              oDigit,
    output logic [NUM_DIGITS-1:0]   oSel,
    output logic                    oDp,
    output logic                    oFrame
);

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] data_snap;
    logic [NUM_DIGITS-1:0]   blink_snap, dp_snap;
    logic                    phase, phase_snap;
    logic                    blank_done, show_done, frame_done, hide;
    logic [NUM_DIGITS-1:0]   sel_nx;
    logic [3:0]              digit_nx;
    logic                    dp_nx, frame_nx;

    smg_tick_cnt #(.N(BLANK_T)) u_blank_cnt (
        .clk(CLK), .rst_n(RSTn), .en(state == BLANK), .done(blank_done)
    );

    smg_tick_cnt #(.N(SHOW_T)) u_show_cnt (
        .clk(CLK), .rst_n(RSTn), .en(state == SHOW), .done(show_done)
    );

    smg_tick_cnt #(.N(BLINK_FRAMES)) u_frame_cnt (
        .clk(CLK), .rst_n(RSTn), .en(state == LOAD), .done(frame_done)
    );

    assign hide = phase_snap & blink_snap[idx];

    // next state and next registered output values; the digit is refreshed only while blanked
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        sel_nx   = '1;
        dp_nx    = 1'b1;
        digit_nx = oDigit;
        frame_nx = 1'b0;
        case (state)
            LOAD: begin
                state_nx = BLANK;
                idx_nx   = '0;
                frame_nx = 1'b1;
            end
            BLANK: begin
                digit_nx = data_snap[{idx, 2'b00} +: 4];
                state_nx = blank_done ? SHOW : BLANK;
            end
            SHOW: begin
                sel_nx = hide ? '1 : sel_mask(idx);
                dp_nx  = hide | ~dp_snap[idx];
                if (show_done) begin
                    state_nx = idx == IDX_W'(NUM_DIGITS - 1) ? LOAD : BLANK;
                    idx_nx   = idx == IDX_W'(NUM_DIGITS - 1) ? idx : idx + IDX_W'(1);
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    // state, position and registered outputs
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            state  <= LOAD;
            idx    <= '0;
            oSel   <= '1;
            oDp    <= 1'b1;
            oDigit <= 4'h0;
            oFrame <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            oSel   <= sel_nx;
            oDp    <= dp_nx;
            oDigit <= digit_nx;
            oFrame <= frame_nx;
        end

    // frame snapshots; the blink phase in force for a frame is the one held before this LOAD's toggle
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            data_snap  <= '0;
            blink_snap <= '0;
            dp_snap    <= '0;
            phase      <= 1'b0;
            phase_snap <= 1'b0;
        end else if (state == LOAD) begin
            data_snap  <= iData;
            blink_snap <= iBlink;
            dp_snap    <= iDp;
            phase_snap <= phase;
            phase      <= phase ^ frame_done;
        end

endmodule
